// File: rtl/isq_bank_pkg.sv
// Shared types for the issue-queue bank: uop entry layout, operand/ALU encodings, dispatch sizing.
// Mirrors the rename-side dispatch payload so the bank stores uops verbatim.
package isq_bank_pkg;

   localparam int DISPATCH_WIDTH       = 2;
   localparam int PHYS_REGS_ADDR_WIDTH = 6;
   localparam int ROB_ADDR_WIDTH       = 5;

   typedef enum logic [1:0] {
      OP_REG,
      OP_IMM,
      OP_PC,
      OP_ZERO
   } op_type_t;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
   } alu_cmd_t;

   // op2 carries an immediate; its low tag bits name a register when op2_type is OP_REG
   typedef struct packed {
      alu_cmd_t                          alu_cmd;
      op_type_t                          op1_type;
      logic                              op1_valid;
      logic [PHYS_REGS_ADDR_WIDTH-1:0]   op1;
      op_type_t                          op2_type;
      logic                              op2_valid;
      logic [31:0]                       op2;
      logic [PHYS_REGS_ADDR_WIDTH-1:0]   phys_rd;
      logic [ROB_ADDR_WIDTH-1:0]         rob_addr;
      logic [31:0]                       pc;
      logic [31:0]                       instr;
   } isq_entry_t;

endpackage

// File: rtl/isq_age_matrix.sv
// Older-than matrix: older_q[r][c] set means slot c was dispatched before slot r.
// Zero-latency oldest pick over req; rows written on allocate, columns cleared on free.
module isq_age_matrix #(
   parameter int DEPTH = 8,
   parameter int LANES = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   input  logic [DEPTH-1:0]             valid_vec,
   input  logic [LANES-1:0][DEPTH-1:0]  alloc_oh,
   input  logic [DEPTH-1:0]             free_vec,
   input  logic [DEPTH-1:0]             req,
   output logic [DEPTH-1:0]             grant
);

   logic [DEPTH-1:0][DEPTH-1:0] older_q;
   logic [DEPTH-1:0][DEPTH-1:0] row_set;
   logic [DEPTH-1:0]            alloc_any;
   logic [DEPTH-1:0]            prior;

   // a new entry is younger than every resident slot and every lower-numbered lane this cycle
   always_comb begin
      prior     = valid_vec;
      row_set   = '0;
      alloc_any = '0;
      for (int i = 0; i < LANES; i++) begin
         for (int s = 0; s < DEPTH; s++) begin
            if (alloc_oh[i][s]) begin
               row_set[s]   = prior;
               alloc_any[s] = 1'b1;
            end
         end
         prior = prior | alloc_oh[i];
      end
   end

   always_comb begin
      for (int r = 0; r < DEPTH; r++) begin
         grant[r] = req[r] && !(|(older_q[r] & req));
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         older_q <= '0;
      end else begin
         for (int r = 0; r < DEPTH; r++) begin
            for (int c = 0; c < DEPTH; c++) begin
               if (free_vec[c])
                  older_q[r][c] <= 1'b0;
               else if (alloc_any[r])
                  older_q[r][c] <= row_set[r][c];
            end
         end
      end
   end

endmodule

// File: rtl/isq_bank.sv
// Issue-queue bank: stores dispatched uops, wakes operands on writeback tags, issues oldest ready uop.
// Dispatch at edge N -> issue from cycle N+1; a held issue waits on issue_ready; full stalls dispatch.
module isq_bank #(
   parameter int DEPTH          = 8,
   parameter int DISPATCH_WIDTH = isq_bank_pkg::DISPATCH_WIDTH,
   parameter int WAKEUP_PORTS   = 2,
   parameter int TAG_W          = isq_bank_pkg::PHYS_REGS_ADDR_WIDTH,
   parameter bit PROTOCOL_CHECK = 1'b1
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          flush,
   input  logic [DISPATCH_WIDTH-1:0]                     disp_en,
   input  isq_bank_pkg::isq_entry_t [DISPATCH_WIDTH-1:0] disp_entry,
   output logic                                          full,
   input  logic [WAKEUP_PORTS-1:0]                       wb_valid,
   input  logic [WAKEUP_PORTS-1:0][TAG_W-1:0]            wb_tag,
   output logic                                          issue_valid,
   input  logic                                          issue_ready,
   output isq_bank_pkg::isq_entry_t                      issue_entry
);

   import isq_bank_pkg::*;

   localparam int             CW        = $clog2(DEPTH + 1);
   localparam logic [CW-1:0]  DW_CNT    = CW'(DISPATCH_WIDTH);
   localparam logic [CW-1:0]  DEPTH_CNT = CW'(DEPTH);

   isq_entry_t                          ent_q [DEPTH];
   logic [DEPTH-1:0]                    slot_vld_q, op1_rdy_q, op2_rdy_q;
   logic [CW-1:0]                       free_cnt_q, free_cnt_nxt;
   logic [DISPATCH_WIDTH-1:0][DEPTH-1:0] alloc_oh;
   logic [DEPTH-1:0]                    avail, alloc_mask, req, grant, issue_free, wake1, wake2;
   logic [DISPATCH_WIDTH-1:0]           lane_op1_rdy, lane_op2_rdy;
   logic                                accept;

   function automatic logic tag_hit(input logic [WAKEUP_PORTS-1:0]            vld,
                                    input logic [WAKEUP_PORTS-1:0][TAG_W-1:0] tags,
                                    input logic [TAG_W-1:0]                   t);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < WAKEUP_PORTS; k++) hit = hit | (vld[k] && (tags[k] == t));
      return hit;
   endfunction

   assign full   = free_cnt_q < DW_CNT;
   assign accept = !full && !flush;

   // lanes claim the lowest free slots in lane order; gaps in disp_en are legal
   always_comb begin
      avail      = ~slot_vld_q;
      alloc_mask = '0;
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
         alloc_oh[i] = '0;
         if (disp_en[i] && accept) begin
            alloc_oh[i] = avail & (~avail + DEPTH'(1));
            avail       = avail & ~alloc_oh[i];
            alloc_mask  = alloc_mask | alloc_oh[i];
         end
         lane_op1_rdy[i] = (disp_entry[i].op1_type != OP_REG) || disp_entry[i].op1_valid ||
                           tag_hit(wb_valid, wb_tag, TAG_W'(disp_entry[i].op1));
         lane_op2_rdy[i] = (disp_entry[i].op2_type != OP_REG) || disp_entry[i].op2_valid ||
                           tag_hit(wb_valid, wb_tag, disp_entry[i].op2[TAG_W-1:0]);
      end
   end

   always_comb begin
      for (int s = 0; s < DEPTH; s++) begin
         wake1[s] = (ent_q[s].op1_type == OP_REG) && tag_hit(wb_valid, wb_tag, TAG_W'(ent_q[s].op1));
         wake2[s] = (ent_q[s].op2_type == OP_REG) && tag_hit(wb_valid, wb_tag, ent_q[s].op2[TAG_W-1:0]);
      end
   end

   assign req         = slot_vld_q & op1_rdy_q & op2_rdy_q;
   assign issue_valid = (|req) && !flush;
   assign issue_free  = (issue_valid && issue_ready) ? grant : '0;

   isq_age_matrix #(
      .DEPTH (DEPTH),
      .LANES (DISPATCH_WIDTH)
   ) u_age (
      .clk       (clk),
      .rst       (rst),
      .clr       (flush),
      .valid_vec (slot_vld_q),
      .alloc_oh  (alloc_oh),
      .free_vec  (issue_free),
      .req       (req),
      .grant     (grant)
   );

   always_comb begin
      issue_entry = '0;
      for (int s = 0; s < DEPTH; s++) begin
         if (grant[s]) issue_entry = ent_q[s];
      end
      issue_entry.op1_valid = 1'b1;
      issue_entry.op2_valid = 1'b1;
   end

   always_comb begin
      free_cnt_nxt = free_cnt_q + CW'(|issue_free);
      for (int s = 0; s < DEPTH; s++) free_cnt_nxt = free_cnt_nxt - CW'(alloc_mask[s]);
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         slot_vld_q <= '0;
         op1_rdy_q  <= '0;
         op2_rdy_q  <= '0;
         free_cnt_q <= DEPTH_CNT;
      end else begin
         free_cnt_q <= free_cnt_nxt;
         for (int s = 0; s < DEPTH; s++) begin
            if (issue_free[s]) slot_vld_q[s] <= 1'b0;
            op1_rdy_q[s] <= op1_rdy_q[s] | wake1[s];
            op2_rdy_q[s] <= op2_rdy_q[s] | wake2[s];
            for (int i = 0; i < DISPATCH_WIDTH; i++) begin
               if (alloc_oh[i][s]) begin
                  slot_vld_q[s] <= 1'b1;
                  ent_q[s]      <= disp_entry[i];
                  op1_rdy_q[s]  <= lane_op1_rdy[i];
                  op2_rdy_q[s]  <= lane_op2_rdy[i];
               end
            end
         end
      end
   end

   generate
      if (PROTOCOL_CHECK) begin : g_proto
         assert property (@(posedge clk) disable iff (rst) !((|disp_en) && full && !flush))
            else $error("isq_bank: dispatch while full, uop dropped");
      end
   endgenerate

endmodule

// File: tb/tb_isq_bank.sv
// Directed bench for isq_bank: ordering, wakeup/bypass timing, full/drop, age select and flush.
module tb_isq_bank;
   import isq_bank_pkg::*;

   logic                   clk = 1'b0;
   logic                   rst, flush, issue_ready, full, issue_valid;
   logic [1:0]             disp_en, wb_valid;
   isq_entry_t [1:0]       disp_entry;
   logic [1:0][5:0]        wb_tag;
   isq_entry_t             issue_entry;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   isq_bank #(
      .PROTOCOL_CHECK (1'b0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .disp_en     (disp_en),
      .disp_entry  (disp_entry),
      .full        (full),
      .wb_valid    (wb_valid),
      .wb_tag      (wb_tag),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_entry (issue_entry)
   );

   function automatic isq_entry_t mk(input op_type_t t1, input logic v1, input logic [5:0] o1,
                                     input op_type_t t2, input logic v2, input logic [31:0] o2,
                                     input logic [4:0] rob);
      isq_entry_t e;
      e           = '0;
      e.alu_cmd   = ALU_ADD;
      e.op1_type  = t1;
      e.op1_valid = v1;
      e.op1       = o1;
      e.op2_type  = t2;
      e.op2_valid = v2;
      e.op2       = o2;
      e.rob_addr  = rob;
      e.phys_rd   = 6'(rob);
      e.pc        = 32'h1000 + 32'(rob) * 4;
      return e;
   endfunction

   function automatic isq_entry_t mk_rdy(input logic [4:0] rob);
      return mk(OP_IMM, 1'b0, 6'd0, OP_IMM, 1'b0, 32'h10 + 32'(rob), rob);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
         else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; issue_ready = 1'b1;
      disp_en = '0; wb_valid = '0; wb_tag = '0; disp_entry = '0;
      tick(); tick();
      chk("reset_full", 32'(full), 32'd0);
      chk("reset_issue_valid", 32'(issue_valid), 32'd0);
      rst = 1'b0;

      // two ready uops in one cycle: lane 0 then lane 1
      disp_en = 2'b11; disp_entry[0] = mk_rdy(5'd1); disp_entry[1] = mk_rdy(5'd2);
      #1;
      chk("no_comb_dispatch_to_issue", 32'(issue_valid), 32'd0);
      tick();
      disp_en = '0;
      chk("t1_iv_n1", 32'(issue_valid), 32'd1);
      chk("t1_rob_n1", 32'(issue_entry.rob_addr), 32'd1);
      chk("t1_op_valids", {30'd0, issue_entry.op1_valid, issue_entry.op2_valid}, 32'd3);
      tick();
      chk("t1_rob_n2", 32'(issue_entry.rob_addr), 32'd2);
      tick();
      chk("t1_empty", 32'(issue_valid), 32'd0);

      // wakeup two cycles after dispatch
      disp_en = 2'b01; disp_entry[0] = mk(OP_REG, 1'b0, 6'd17, OP_IMM, 1'b0, 32'h5, 5'd3);
      tick();
      disp_en = '0;
      chk("t2_wait_n1", 32'(issue_valid), 32'd0);
      wb_valid = 2'b01; wb_tag[0] = 6'd16;
      tick();
      chk("t2_wrong_tag", 32'(issue_valid), 32'd0);
      wb_valid = 2'b10; wb_tag[1] = 6'd17;
      #1;
      chk("t2_no_comb_wakeup", 32'(issue_valid), 32'd0);
      tick();
      wb_valid = '0;
      chk("t2_woken_iv", 32'(issue_valid), 32'd1);
      chk("t2_woken_rob", 32'(issue_entry.rob_addr), 32'd3);
      chk("t2_op1_tag", 32'(issue_entry.op1), 32'd17);
      chk("t2_op1_valid", 32'(issue_entry.op1_valid), 32'd1);
      tick();
      chk("t2_empty", 32'(issue_valid), 32'd0);

      // bypass on lane 1 only, op2 tag in low bits of a wide field
      disp_en = 2'b10;
      disp_entry[1] = mk(OP_IMM, 1'b0, 6'd0, OP_REG, 1'b0, 32'hABCD_0009, 5'd4);
      wb_valid = 2'b01; wb_tag[0] = 6'd9;
      tick();
      disp_en = '0; wb_valid = '0;
      chk("t3_bypass_iv", 32'(issue_valid), 32'd1);
      chk("t3_bypass_rob", 32'(issue_entry.rob_addr), 32'd4);
      tick();
      chk("t3_empty", 32'(issue_valid), 32'd0);

      // fill with the pipe stalled
      issue_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         disp_en = 2'b11;
         disp_entry[0] = mk_rdy(5'(10 + 2 * c));
         disp_entry[1] = mk_rdy(5'(11 + 2 * c));
         tick();
         chk("t4_fill_not_full", 32'(full), 32'd0);
      end
      disp_en = 2'b01; disp_entry[0] = mk_rdy(5'd16);
      tick();
      chk("t4_full_at_7", 32'(full), 32'd1);
      disp_en = 2'b11; disp_entry[0] = mk_rdy(5'd30); disp_entry[1] = mk_rdy(5'd31);
      tick();
      disp_en = '0;
      chk("t4_drop_full", 32'(full), 32'd1);
      chk("t4_hold_rob", 32'(issue_entry.rob_addr), 32'd10);
      issue_ready = 1'b1;
      #1;
      chk("t4_no_comb_ready_full", 32'(full), 32'd1);
      for (int k = 0; k < 7; k++) begin
         chk("t4_drain_iv", 32'(issue_valid), 32'd1);
         chk("t4_drain_rob", 32'(issue_entry.rob_addr), 32'(10 + k));
         tick();
         if (k == 0) chk("t4_full_after_issue", 32'(full), 32'd0);
      end
      chk("t4_dropped_absent", 32'(issue_valid), 32'd0);

      // age: B issues while A waits; woken A beats younger C
      disp_en = 2'b01; disp_entry[0] = mk(OP_REG, 1'b0, 6'd5, OP_IMM, 1'b0, 32'h0, 5'd20);
      tick();
      chk("t5_a_waiting", 32'(issue_valid), 32'd0);
      disp_entry[0] = mk_rdy(5'd21);
      tick();
      chk("t5_b_first", 32'(issue_entry.rob_addr), 32'd21);
      disp_entry[0] = mk_rdy(5'd22);
      wb_valid = 2'b01; wb_tag[0] = 6'd5;
      tick();
      disp_en = '0; wb_valid = '0;
      chk("t5_a_over_c_iv", 32'(issue_valid), 32'd1);
      chk("t5_a_over_c", 32'(issue_entry.rob_addr), 32'd20);
      tick();
      chk("t5_c_last", 32'(issue_entry.rob_addr), 32'd22);
      tick();
      chk("t5_empty", 32'(issue_valid), 32'd0);

      // flush with 5 resident and a concurrent dispatch/wakeup
      issue_ready = 1'b0;
      disp_en = 2'b11; disp_entry[0] = mk_rdy(5'd8); disp_entry[1] = mk_rdy(5'd9);
      tick();
      disp_entry[0] = mk_rdy(5'd12); disp_entry[1] = mk_rdy(5'd13);
      tick();
      disp_en = 2'b01; disp_entry[0] = mk_rdy(5'd14);
      tick();
      disp_en = '0;
      chk("t6_pre_iv", 32'(issue_valid), 32'd1);
      chk("t6_pre_rob", 32'(issue_entry.rob_addr), 32'd8);
      chk("t6_pre_full", 32'(full), 32'd0);
      flush = 1'b1; disp_en = 2'b11; disp_entry[0] = mk_rdy(5'd25); disp_entry[1] = mk_rdy(5'd26);
      wb_valid = 2'b11; issue_ready = 1'b1;
      #1;
      chk("t6_flush_iv", 32'(issue_valid), 32'd0);
      tick();
      flush = 1'b0; disp_en = '0; wb_valid = '0;
      chk("t6_post_iv", 32'(issue_valid), 32'd0);
      chk("t6_post_full", 32'(full), 32'd0);
      tick();
      chk("t6_post_iv2", 32'(issue_valid), 32'd0);

      // free count restored to DEPTH after flush
      issue_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         disp_en = 2'b11;
         disp_entry[0] = mk_rdy(5'(2 * c));
         disp_entry[1] = mk_rdy(5'(2 * c + 1));
         tick();
      end
      chk("t6_refill_6", 32'(full), 32'd0);
      disp_en = 2'b01; disp_entry[0] = mk_rdy(5'd6);
      tick();
      disp_en = '0;
      chk("t6_refill_7", 32'(full), 32'd1);
      chk("t6_refill_rob", 32'(issue_entry.rob_addr), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
